pwm_meas: RTL and testbench
===========================

// Module: pwm_meas
// PURPOSE
//   Measures a digital PWM waveform, e.g. the output of the pwm model. It is the
//   receive-side counterpart of that generator.
//   Samples `in` once per emulation step (cke=1). Reports the high time and the
//   period, both in emulation steps, after every complete rising-to-rising cycle.
//   Sits in the emulator on CLK_MSDSL/RST_MSDSL alongside the other msdsl models.
//   Used to close loops on PWM-driven converter models and to self-check PWM sources.
// PARAMETERS
//   width   16  width of all step counters and count outputs
//   init    0   level assumed for `in` before the first sample (edge-detect history)
// PORTS
//   clk         input   1      clock
//   rst         input   1      reset, synchronous, active-high
//   cke         input   1      sample enable (one emulation step per cke=1 cycle)
//   in          input   1      PWM waveform under measurement
//   high_cnt    output  width  steps `in` was high in last complete cycle
//   period_cnt  output  width  steps between last two rising edges
//   valid       output  1      one-cycle pulse: high_cnt/period_cnt just updated
//   stuck       output  1      level: counter saturated with no edge (0%/100% duty or too slow)
// BEHAVIOUR
//   Reset:
//     - state=SYNC; cnt, hcnt, high_cnt, period_cnt = 0; valid=0; stuck=0; last=init.
//   Sampling and edge detection:
//     - `last` updates to `in` only on cke=1.
//     - rise = cke & in & ~last; fall = cke & ~in & last.
//     - cke=0: every register holds, and valid=0.
//   FSM (all transitions on posedge clk, only when cke=1):
//     SYNC:
//       - rise -> HIGH, cnt<=1. No output update; first rise after reset/stuck only resyncs.
//       - Otherwise stay in SYNC; cnt does not run.
//     HIGH:
//       - fall -> LOW, hcnt<=cnt, cnt<=cnt+1.
//       - No edge -> cnt<=cnt+1.
//     LOW:
//       - rise -> HIGH, high_cnt<=hcnt, period_cnt<=cnt, valid<=1, stuck<=0, cnt<=1.
//       - No edge -> cnt<=cnt+1.
//   Counting convention:
//     - cnt counts samples from the rising-edge sample (=1) onward.
//     - Example: 3 samples high, then 2 low -> high_cnt=3, period_cnt=5.
//   Latency:
//     - valid and the new counts become visible together in the cycle after the clock edge
//       that samples the rise.
//     - valid is high for exactly one clk cycle.
//   Saturation:
//     - Applies in HIGH or LOW, when cnt==2^width-1 and a cke sample brings no edge.
//     - Action: state<=SYNC, stuck<=1, no valid.
//     - high_cnt/period_cnt keep their last values.
//     - cnt never wraps.
//   stuck:
//     - Clears only on the next valid, or on rst.
//   Minimum waveform:
//     - 1 step high, 1 step low -> high_cnt=1, period_cnt=2, valid every 2 samples.
//   Reset mid-measurement:
//     - Partial counts are discarded.
//     - The next valid requires two rising edges after reset.
//   Arithmetic:
//     - Unsigned, width bits; no signed values.
// TESTING
//   1. cke=1 always; in=3 high/2 low repeating -> after 2nd rise, valid pulses every 5 cycles
//      with high_cnt=3, period_cnt=5; nothing before 2nd rise.
//   2. cke toggling 1/0; same 3/2 pattern per sample -> same counts; valid only in the cycle
//      after a cke=1 rise sample; all regs hold while cke=0.
//   3. width=4; in held high 20 samples after a rise -> stuck=1 after 15th count + 1 sample,
//      no valid. Then 2/2 PWM -> valid after 2nd rise with 2/4, and stuck=0.
//   4. rst asserted mid-HIGH of 3/2 stream -> all outputs 0 next cycle. First rise after
//      reset gives no valid; the following rise gives 3/5.
//   5. 1 high/1 low -> high_cnt=1, period_cnt=2, valid every 2nd cycle; init=1 with in=1
//      at reset -> first high sample is not a rise.
//   6. Drive from pwm model (period=10 dt, duty=0.3) -> steady high_cnt=3 (+/-1),
//      period_cnt=10 (+/-1), stuck=0.

Source files
------------

// File: rtl/pwm_meas.sv
// PWM measurement: samples `in` on each cke step and reports high time and
// period (in steps) after every complete rising-to-rising cycle.
module pwm_meas #(
  parameter int unsigned width = 16,
  parameter logic        init  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cke,
  input  logic             in,
  output logic [width-1:0] high_cnt,
  output logic [width-1:0] period_cnt,
  output logic             valid,
  output logic             stuck
);

  localparam logic [1:0] SYNC = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  localparam logic [width-1:0] CNT_MAX = '1;
  localparam logic [width-1:0] CNT_ONE = width'(1);

  logic [1:0]       state_q, state_d;
  logic [width-1:0] cnt_q, cnt_d;
  logic [width-1:0] hcnt_q, hcnt_d;
  logic [width-1:0] high_cnt_q, high_cnt_d;
  logic [width-1:0] period_cnt_q, period_cnt_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             last_q, last_d;

  logic             rise;
  logic             fall;
  logic             cnt_at_max;
  logic [width-1:0] cnt_inc;

  assign rise       = cke & in & ~last_q;
  assign fall       = cke & ~in & last_q;
  assign cnt_at_max = (cnt_q == CNT_MAX);
  // A fall landing exactly on the maximum count must not wrap the counter;
  // the following no-edge LOW sample then flags stuck.
  assign cnt_inc    = cnt_at_max ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hcnt_d       = hcnt_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    valid_d      = 1'b0;
    stuck_d      = stuck_q;
    last_d       = cke ? in : last_q;

    if (cke) begin
      case (state_q)
        SYNC: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            hcnt_d  = cnt_q;
            cnt_d   = cnt_inc;
          end else if (cnt_at_max) begin
            state_d = SYNC;
            stuck_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            state_d      = HIGH;
            high_cnt_d   = hcnt_q;
            period_cnt_d = cnt_q;
            valid_d      = 1'b1;
            stuck_d      = 1'b0;
            cnt_d        = CNT_ONE;
          end else if (cnt_at_max) begin
            state_d = SYNC;
            stuck_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      last_q       <= init;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      last_q       <= last_d;
    end
  end

  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign valid      = valid_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas: vector table plus hand sequences for
// saturation/stuck recovery and a long PWM stream.
module tb_pwm_meas;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cke = 1'b0;
  logic in  = 1'b0;

  logic [15:0] high_a, period_a;
  logic        valid_a, stuck_a;
  logic [3:0]  high_b, period_b;
  logic        valid_b, stuck_b;
  logic [15:0] high_c, period_c;
  logic        valid_c, stuck_c;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pwm_meas #(.width(16), .init(1'b0)) dut_a (
    .clk(clk), .rst(rst), .cke(cke), .in(in),
    .high_cnt(high_a), .period_cnt(period_a), .valid(valid_a), .stuck(stuck_a)
  );

  pwm_meas #(.width(4), .init(1'b0)) dut_b (
    .clk(clk), .rst(rst), .cke(cke), .in(in),
    .high_cnt(high_b), .period_cnt(period_b), .valid(valid_b), .stuck(stuck_b)
  );

  pwm_meas #(.width(16), .init(1'b1)) dut_c (
    .clk(clk), .rst(rst), .cke(cke), .in(in),
    .high_cnt(high_c), .period_cnt(period_c), .valid(valid_c), .stuck(stuck_c)
  );

  typedef struct {
    logic        r;
    logic        c;
    logic        i;
    int          d;
    logic        v;
    logic [15:0] h;
    logic [15:0] p;
    logic        s;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, c, i, input int d, input logic v,
                     input logic [15:0] h, p, input logic s);
    vec_t e;
    e.r = r; e.c = c; e.i = i; e.d = d; e.v = v; e.h = h; e.p = p; e.s = s;
    vecs.push_back(e);
  endtask

  task automatic step(input logic r, c, i);
    rst = r;
    cke = c;
    in  = i;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int d, input logic ev,
                       input logic [15:0] eh, ep, input logic es);
    logic        av, as;
    logic [15:0] ah, ap;
    case (d)
      1:       begin av = valid_b; as = stuck_b; ah = {12'd0, high_b}; ap = {12'd0, period_b}; end
      2:       begin av = valid_c; as = stuck_c; ah = high_c; ap = period_c; end
      default: begin av = valid_a; as = stuck_a; ah = high_a; ap = period_a; end
    endcase
    n_vec++;
    if ({av, ah, ap, as} !== {ev, eh, ep, es}) begin
      n_err++;
      $display("FAIL %s dut%0d: got valid=%0b high=%0d period=%0d stuck=%0b, want valid=%0b high=%0d period=%0d stuck=%0b",
               name, d, av, ah, ap, as, ev, eh, ep, es);
    end
  endtask

  initial begin
    // 3 high / 2 low, cke=1, then reset mid-HIGH and resync
    add(1,1,0,0, 0,0,0,0);
    add(0,1,1,0, 0,0,0,0); add(0,1,1,0, 0,0,0,0); add(0,1,1,0, 0,0,0,0);
    add(0,1,0,0, 0,0,0,0); add(0,1,0,0, 0,0,0,0);
    add(0,1,1,0, 1,3,5,0); add(0,1,1,0, 0,3,5,0); add(0,1,1,0, 0,3,5,0);
    add(0,1,0,0, 0,3,5,0); add(0,1,0,0, 0,3,5,0);
    add(0,1,1,0, 1,3,5,0); add(0,1,1,0, 0,3,5,0);
    add(1,1,1,0, 0,0,0,0);
    add(0,1,0,0, 0,0,0,0); add(0,1,0,0, 0,0,0,0);
    add(0,1,1,0, 0,0,0,0); add(0,1,1,0, 0,0,0,0); add(0,1,1,0, 0,0,0,0);
    add(0,1,0,0, 0,0,0,0); add(0,1,0,0, 0,0,0,0);
    add(0,1,1,0, 1,3,5,0); add(0,1,1,0, 0,3,5,0);
    // same pattern with cke toggling; in wiggles while cke=0
    add(1,1,0,0, 0,0,0,0);
    add(0,1,1,0, 0,0,0,0); add(0,0,0,0, 0,0,0,0);
    add(0,1,1,0, 0,0,0,0); add(0,0,1,0, 0,0,0,0);
    add(0,1,1,0, 0,0,0,0); add(0,0,0,0, 0,0,0,0);
    add(0,1,0,0, 0,0,0,0); add(0,0,1,0, 0,0,0,0);
    add(0,1,0,0, 0,0,0,0); add(0,0,0,0, 0,0,0,0);
    add(0,1,1,0, 1,3,5,0); add(0,0,0,0, 0,3,5,0); add(0,0,1,0, 0,3,5,0);
    add(0,1,1,0, 0,3,5,0);
    // minimum waveform 1/1
    add(1,1,0,0, 0,0,0,0);
    add(0,1,1,0, 0,0,0,0); add(0,1,0,0, 0,0,0,0);
    add(0,1,1,0, 1,1,2,0); add(0,1,0,0, 0,1,2,0);
    add(0,1,1,0, 1,1,2,0); add(0,1,0,0, 0,1,2,0);
    add(0,1,1,0, 1,1,2,0);
    // init=1: a high first sample is not a rise
    add(1,1,1,2, 0,0,0,0);
    add(0,1,1,2, 0,0,0,0); add(0,1,1,2, 0,0,0,0); add(0,1,0,2, 0,0,0,0);
    add(0,1,1,2, 0,0,0,0); add(0,1,0,2, 0,0,0,0);
    add(0,1,1,2, 1,1,2,0);

    foreach (vecs[k]) begin
      step(vecs[k].r, vecs[k].c, vecs[k].i);
      check($sformatf("vec%0d", k), vecs[k].d, vecs[k].v, vecs[k].h, vecs[k].p, vecs[k].s);
    end

    // width=4 saturation: get 1/2, hold high until stuck, then recover with 2/2
    step(1,1,0); check("sat_rst", 1, 0,0,0,0);
    step(0,1,1); check("sat_r1", 1, 0,0,0,0);
    step(0,1,0); check("sat_f1", 1, 0,0,0,0);
    step(0,1,1); check("sat_r2", 1, 1,1,2,0);
    for (int k = 1; k <= 14; k++) begin
      step(0,1,1); check($sformatf("sat_hold%0d", k), 1, 0,1,2,0);
    end
    step(0,1,1); check("sat_stuck", 1, 0,1,2,1);
    for (int k = 0; k < 5; k++) begin
      step(0,1,1); check($sformatf("sat_stay%0d", k), 1, 0,1,2,1);
    end
    step(0,1,0); check("rec_l0", 1, 0,1,2,1);
    step(0,1,0); check("rec_l1", 1, 0,1,2,1);
    step(0,1,1); check("rec_resync", 1, 0,1,2,1);
    step(0,1,1); check("rec_h1", 1, 0,1,2,1);
    step(0,1,0); check("rec_l2", 1, 0,1,2,1);
    step(0,1,0); check("rec_l3", 1, 0,1,2,1);
    step(0,1,1); check("rec_valid", 1, 1,2,4,0);
    step(0,1,1); check("rec_after", 1, 0,2,4,0);

    // period 10, duty 0.3 stream
    step(1,1,0); check("pwm_rst", 0, 0,0,0,0);
    for (int k = 0; k < 60; k++) begin
      logic        lvl, ev;
      logic [15:0] eh, ep;
      lvl = ((k % 10) < 3);
      ev  = (k >= 10) && ((k % 10) == 0);
      eh  = (k >= 10) ? 16'd3 : 16'd0;
      ep  = (k >= 10) ? 16'd10 : 16'd0;
      step(0,1,lvl);
      check($sformatf("pwm%0d", k), 0, ev, eh, ep, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
